stack_unit: RTL
===============

Name: stack_unit

Overview:
- Hardware LIFO stack. It is the responder side of the push/pop command interface issued by the sort/ALU controller.
- Two instances (stack A, stack B) return their depth as the 5-bit position the controller compares against (0, 1, >1).
- Each instance holds the current top-of-stack in a register so the comparator and ALU can read it without a pop.
- Popped words are returned one cycle after the command.

Parameters:
- WIDTH, 16, data word width; bit WIDTH-1 is the sign bit the controller uses for A/B routing.
- PTR_W, 5, width of the position counter.
- DEPTH, 31, number of entries; must be ≤ 2^PTR_W - 1 so a full stack is representable in pos.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear: empties the stack and clears the error flags
- push  in  1  push request, single-cycle strobe
- pop  in  1  pop request, single-cycle strobe
- din  in  WIDTH  data to push, sampled on a clk edge with push=1
- dout  out  WIDTH  popped word, registered
- dout_vld  out  1  one-cycle pulse: dout is valid
- top  out  WIDTH  current top-of-stack, registered; 0 when empty
- pos  out  PTR_W  number of entries held (0..DEPTH)
- empty  out  1  pos==0
- full  out  1  pos==DEPTH
- ovf  out  1  sticky: push attempted while full
- udf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst=0, asynchronous): pos=0, top=0, dout=0, dout_vld=0, ovf=0, udf=0; empty=1, full=0.
- Memory contents are don't-care after reset.
- Storage is a register array mem[0..DEPTH-1]; mem[pos-1] is the top entry. empty and full are decoded combinationally from pos.
- Command decode each cycle (clr has the highest priority):
  - clr=1: pos=0, top=0, ovf=0, udf=0, dout_vld=0. push and pop are ignored that cycle.
  - push only, not full: mem[pos]=din; pos=pos+1; top=din.
  - push only, full: no change to storage or pos; ovf=1.
  - pop only, not empty: dout=mem[pos-1]; dout_vld=1 next cycle; pos=pos-1; top=mem[pos-2] if pos≥2, else 0.
  - pop only, empty: dout holds its previous value; dout_vld=0; udf=1.
  - push and pop together, not empty (replace): dout=old top; dout_vld=1; mem[pos-1]=din; top=din; pos unchanged.
  - push and pop together, empty: behaves as push only (pos becomes 1, top=din); udf=1; dout_vld=0.
  - Neither asserted: dout_vld=0; all state holds.
- Latency:
  - pos and top reflect a command on the cycle after the clock edge that sampled it.
  - dout and dout_vld become valid on that same cycle.
- Back-to-back pops on consecutive cycles are legal, with one dout_vld pulse per pop, until empty.
- Width rules:
  - pos arithmetic is PTR_W-bit and unsigned. Over/underflow guards prevent wrap, so pos never exceeds DEPTH and never goes below 0.
  - Data passes through unmodified; no sign handling inside the block.
- ovf and udf stay set until clr or reset.
- Reset mid-operation: an in-flight dout_vld pulse is killed immediately (asynchronous).

Optional Feature:
- Macro: STACK_HWM_EN.
- Defined:
  - Adds output hwm [PTR_W-1:0], a high-water mark register.
  - hwm updates to pos_next whenever pos_next > hwm.
  - Reset sets hwm=0; clr also sets hwm=0.
  - Used for depth-sizing runs.
- Not defined: no hwm port or register. All other behaviour is identical.

Test Plan:
- Reset then idle → pos=0, empty=1, top=0, dout_vld never asserted, ovf=udf=0.
- Push 0x0005, 0x8003, 0x7FFF; then pop 3 times on consecutive cycles:
  - After the pushes: pos=3, top=0x7FFF.
  - Pops: dout=0x7FFF, 0x8003, 0x0005 with dout_vld=1 each cycle.
  - Finally: pos=0, top=0, empty=1.
- Push 31 values (i+1), then one more push of 0xAAAA → full=1, pos=31, ovf=1, top=31. A following pop returns dout=31, pos=30.
- Pop when empty → udf=1, dout_vld=0, pos=0. Then assert clr → udf=0.
- With pos=2 and top=0x0010, push 0x0020 and pop together → dout=0x0010, dout_vld=1, top=0x0020, pos=2. A later pop returns 0x0020.
- Push twice, then drive rst low asynchronously mid-cycle → pos=0 and top=0 immediately. With STACK_HWM_EN defined, hwm=0 after reset and hwm=2 after the two pushes.

Source files
------------

// File: rtl/stack_unit.sv
// LIFO stack with registered top-of-stack and one-cycle popped-word return; sticky over/underflow flags.
// Optional high-water-mark output enabled by defining STACK_HWM_EN.
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int PTR_W = 5,
  parameter int DEPTH = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W-1:0] pos,
  output logic             empty,
  output logic             full,
  output logic             ovf,
`ifdef STACK_HWM_EN
  output logic             udf,
  output logic [PTR_W-1:0] hwm
`else
  output logic             udf
`endif
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO   = PTR_W'(2);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic [PTR_W-1:0] pos_next;
  logic [WIDTH-1:0] top_next;
  logic [WIDTH-1:0] dout_next;
  logic             vld_next;
  logic             ovf_next;
  logic             udf_next;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  assign empty = (pos == '0);
  assign full  = (pos == PTR_DEPTH);

  always_comb begin
    pos_next  = pos;
    top_next  = top;
    dout_next = dout;
    vld_next  = 1'b0;
    ovf_next  = ovf;
    udf_next  = udf;
    wr_en     = 1'b0;
    wr_idx    = pos;
    if (clr) begin
      pos_next = '0;
      top_next = '0;
      ovf_next = 1'b0;
      udf_next = 1'b0;
    end else if (push && pop) begin
      if (empty) begin
        wr_en    = 1'b1;
        wr_idx   = '0;
        pos_next = PTR_ONE;
        top_next = din;
        udf_next = 1'b1;
      end else begin
        // Replace: top register always mirrors mem[pos-1], so it is the outgoing word.
        dout_next = top;
        vld_next  = 1'b1;
        wr_en     = 1'b1;
        wr_idx    = pos - PTR_ONE;
        top_next  = din;
      end
    end else if (push) begin
      if (full) begin
        ovf_next = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_idx   = pos;
        pos_next = pos + PTR_ONE;
        top_next = din;
      end
    end else if (pop) begin
      if (empty) begin
        udf_next = 1'b1;
      end else begin
        dout_next = top;
        vld_next  = 1'b1;
        pos_next  = pos - PTR_ONE;
        top_next  = (pos >= PTR_TWO) ? mem[pos - PTR_TWO] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos      <= '0;
      top      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      pos      <= pos_next;
      top      <= top_next;
      dout     <= dout_next;
      dout_vld <= vld_next;
      ovf      <= ovf_next;
      udf      <= udf_next;
    end
  end

`ifdef STACK_HWM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm <= '0;
    end else if (clr) begin
      hwm <= '0;
    end else if (pos_next > hwm) begin
      hwm <= pos_next;
    end
  end
`endif

endmodule
